config_loader: RTL and testbench

CONFIG_LOADER -- requirements
Module: config_loader

---
 rtl/config_loader.sv | 122 ++++++++++++
 tb/tb_config_loader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/config_loader.sv
// Streams a frame of configuration words into a latch array: each accepted word is
// placed on io_d_out and written by a one-cycle, flop-driven one-hot enable pulse.
module config_loader #(
    parameter int NUM_WORDS  = 45,
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  io_start,
    input  logic                  io_abort,
    input  logic                  io_in_valid,
    input  logic [WORD_WIDTH-1:0] io_in_data,
    output logic                  io_in_ready,
    output logic [WORD_WIDTH-1:0] io_d_out,
    output logic [NUM_WORDS-1:0]  io_configs_en,
    output logic                  io_busy,
    output logic                  io_done,
    output logic [WORD_WIDTH-1:0] io_checksum
);

    // state  | meaning
    // IDLE   | no frame in progress, waiting for io_start
    // WAIT   | ready for the next word; handshake captures it onto io_d_out
    // SETUP  | data settles on the latch bus, enables low
    // STROBE | enable bit[counter] high
    // HOLD   | enables low, data held; advance counter or finish
    // DONE   | one-cycle completion pulse
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_DONE
    } state_t;

    localparam int CW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NUM_WORDS - 1);

    state_t                 state_q, state_d;
    logic [CW-1:0]          count_q, count_d;
    logic [WORD_WIDTH-1:0]  d_out_q, d_out_d;
    logic [WORD_WIDTH-1:0]  chk_q, chk_d;
    logic [NUM_WORDS-1:0]   en_q, en_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            d_out_q <= '0;
            chk_q   <= '0;
            en_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            d_out_q <= d_out_d;
            chk_q   <= chk_d;
            en_q    <= en_d;
        end
    end

    // The enable register is loaded only on the SETUP->STROBE edge, so its output
    // is a clean flop pulse and every other edge (including abort) clears it.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        d_out_d = d_out_q;
        chk_d   = chk_q;
        en_d    = '0;
        if (io_abort && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (io_start) begin
                        state_d = ST_WAIT;
                        count_d = '0;
                        chk_d   = '0;
                    end
                end
                ST_WAIT: begin
                    if (io_in_valid) begin
                        d_out_d = io_in_data;
                        chk_d   = chk_q ^ io_in_data;
                        state_d = ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    en_d    = NUM_WORDS'(1) << count_q;
                    state_d = ST_STROBE;
                end
                ST_STROBE: begin
                    state_d = ST_HOLD;
                end
                ST_HOLD: begin
                    if (count_q == LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        count_d = count_q + CW'(1);
                        state_d = ST_WAIT;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    assign io_in_ready   = (state_q == ST_WAIT);
    assign io_busy       = (state_q != ST_IDLE);
    assign io_done       = (state_q == ST_DONE);
    assign io_d_out      = d_out_q;
    assign io_checksum   = chk_q;
    assign io_configs_en = en_q;

endmodule

// File: tb/tb_config_loader.sv
// Bench for config_loader: a timestamp-based frame model predicts every output each
// cycle; directed scenarios plus random traffic drive it.
module tb_config_loader;

    localparam int NW  = 45;
    localparam int WW  = 32;
    localparam int BIG = 1 << 30;

    logic          clk;
    logic          reset;
    logic          io_start;
    logic          io_abort;
    logic          io_in_valid;
    logic [WW-1:0] io_in_data;
    logic          io_in_ready;
    logic [WW-1:0] io_d_out;
    logic [NW-1:0] io_configs_en;
    logic          io_busy;
    logic          io_done;
    logic [WW-1:0] io_checksum;

    config_loader #(.NUM_WORDS(NW), .WORD_WIDTH(WW)) dut (
        .clk          (clk),
        .reset        (reset),
        .io_start     (io_start),
        .io_abort     (io_abort),
        .io_in_valid  (io_in_valid),
        .io_in_data   (io_in_data),
        .io_in_ready  (io_in_ready),
        .io_d_out     (io_d_out),
        .io_configs_en(io_configs_en),
        .io_busy      (io_busy),
        .io_done      (io_done),
        .io_checksum  (io_checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Model: a frame is described by timestamps (edge numbers), not by states.
    bit            m_active;
    int            m_wait_from;
    int            m_done_at;
    int            m_hs;
    bit            m_hs_vld;
    int            m_hs_idx;
    int            m_idx;
    logic [WW-1:0] m_dout;
    logic [WW-1:0] m_chk;

    task automatic check1(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [NW-1:0] exp_en();
        logic [NW-1:0] e;
        e = '0;
        if (m_active && m_hs_vld && cyc == m_hs + 1) e[m_hs_idx] = 1'b1;
        return e;
    endfunction

    function automatic bit exp_ready();
        return m_active && cyc >= m_wait_from;
    endfunction

    task automatic check_all();
        check1("ready",    64'(io_in_ready),   64'(exp_ready()));
        check1("busy",     64'(io_busy),       64'(m_active));
        check1("done",     64'(io_done),       64'(m_active && cyc == m_done_at));
        check1("en",       64'(io_configs_en), 64'(exp_en()));
        check1("d_out",    64'(io_d_out),      64'(m_dout));
        check1("checksum", 64'(io_checksum),   64'(m_chk));
    endtask

    task automatic model_reset();
        m_active    = 1'b0;
        m_wait_from = BIG;
        m_done_at   = BIG;
        m_hs        = -10;
        m_hs_vld    = 1'b0;
        m_hs_idx    = 0;
        m_idx       = 0;
        m_dout      = '0;
        m_chk       = '0;
    endtask

    // Called at a falling edge: drive inputs, predict the next rising edge, then check.
    task automatic step(input bit st, input bit ab, input bit vl, input logic [WW-1:0] dt);
        io_start    = st;
        io_abort    = ab;
        io_in_valid = vl;
        io_in_data  = dt;
        if (m_active) begin
            if (ab) begin
                m_active    = 1'b0;
                m_idx       = 0;
                m_hs_vld    = 1'b0;
                m_wait_from = BIG;
                m_done_at   = BIG;
            end else if (cyc == m_done_at) begin
                m_active = 1'b0;
            end else if (cyc >= m_wait_from && vl) begin
                m_hs     = cyc + 1;
                m_hs_vld = 1'b1;
                m_hs_idx = m_idx;
                m_dout   = dt;
                m_chk    = m_chk ^ dt;
                if (m_idx == NW - 1) begin
                    m_wait_from = BIG;
                    m_done_at   = m_hs + 3;
                end else begin
                    m_wait_from = m_hs + 3;
                    m_idx++;
                end
            end
        end else if (st) begin
            m_active    = 1'b1;
            m_wait_from = cyc + 1;
            m_done_at   = BIG;
            m_idx       = 0;
            m_chk       = '0;
            m_hs_vld    = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    function automatic logic [WW-1:0] word_for(int i);
        return WW'(32'h1000 + i);
    endfunction

    initial begin
        int s;
        int done_seen;
        int pulses;
        logic [NW-1:0] first_en;
        int guard;
        logic [WW-1:0] chk_before;

        io_start = 0; io_abort = 0; io_in_valid = 0; io_in_data = '0;
        reset = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all();
        check1("reset_en_literal", 64'(io_configs_en), 64'd0);
        reset = 1'b1;
        repeat (3) step(0, 0, 1, $urandom);

        // Frame A: backpressure before word 3, stray start at word 5, abort in STROBE of word 10
        step(1, 0, 0, 0);
        guard = 400;
        while (!(exp_ready() && m_idx == 3) && guard > 0) begin
            step(0, 0, 1, exp_ready() ? word_for(m_idx) : $urandom);
            guard--;
        end
        check1("bp_reach_timeout", 64'(guard > 0), 64'd1);
        for (int i = 0; i < 7; i++) begin
            step(0, 0, 0, $urandom);
            check1("bp_ready_literal", 64'(io_in_ready), 64'd1);
            check1("bp_en_literal", 64'(io_configs_en), 64'd0);
        end
        guard = 400;
        while (!(exp_en() != 0 && m_hs_idx == 10) && guard > 0) begin
            step((m_idx == 5) ? 1'b1 : 1'b0, 0, 1, exp_ready() ? word_for(m_idx) : $urandom);
            guard--;
        end
        check1("strobe10_timeout", 64'(guard > 0), 64'd1);
        check1("strobe10_literal", 64'(io_configs_en), 64'(1) << 10);
        step(0, 1, 1, $urandom);
        check1("abort_busy_literal", 64'(io_busy), 64'd0);
        check1("abort_en_literal", 64'(io_configs_en), 64'd0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, $urandom);

        // Frame B: full frame with valid held high
        step(1, 0, 1, $urandom);
        s = cyc;
        done_seen = -1; pulses = 0; first_en = '0;
        guard = 250;
        while ((m_active || cyc == s) && guard > 0) begin
            step(0, 0, 1, exp_ready() ? word_for(m_idx) : $urandom);
            if (io_configs_en != 0) begin
                if (pulses == 0) first_en = io_configs_en;
                pulses++;
            end
            if (io_done) done_seen = cyc;
            guard--;
        end
        check1("frame_timeout", 64'(guard > 0), 64'd1);
        check1("frame_done_latency", 64'(done_seen - s), 64'd180);
        check1("frame_pulses", 64'(pulses), 64'd45);
        check1("reload_first_en", 64'(first_en), 64'd1);
        check1("frame_checksum_literal", 64'(io_checksum), 64'h102C);
        check1("frame_dout_literal", 64'(io_d_out), 64'h102C);

        // Abort collides with a valid word in WAIT
        step(1, 0, 0, 0);
        step(0, 0, 1, 32'hDEAD_BEEF);
        guard = 20;
        while (!exp_ready() && guard > 0) begin
            step(0, 0, 0, $urandom);
            guard--;
        end
        chk_before = io_checksum;
        step(0, 1, 1, 32'h1234_5678);
        check1("abort_valid_chk", 64'(io_checksum), 64'(chk_before));
        check1("abort_valid_busy", 64'(io_busy), 64'd0);

        // Asynchronous reset in the middle of a STROBE cycle
        step(1, 0, 0, 0);
        guard = 20;
        while (exp_en() == 0 && guard > 0) begin
            step(0, 0, 1, 32'hA5A5_0000 + WW'(cyc));
            guard--;
        end
        check1("strobe_timeout", 64'(guard > 0), 64'd1);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check1("async_en_literal", 64'(io_configs_en), 64'd0);
        check_all();
        @(negedge clk);
        reset = 1'b1;
        step(0, 0, 1, $urandom);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 9) == 0, $urandom_range(0, 149) == 0,
                 $urandom_range(0, 3) != 0, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
